ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch_if.sv | 26 ++
 rtl/ifu_fetch.sv | 94 +++++++++
 tb/tb_ifu_fetch.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory port, decode-side handshake.
// Latency: none, signal grouping only.
// Backpressure: carries inst_ready_i from decode; the memory side is always ready.
interface ifu_fetch_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;

  // Fetch unit side
  modport master (
    input  jump_en_i, jump_addr_i, imem_rdata_i, inst_ready_i,
    output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );

  // Execute / memory / decode side
  modport slave (
    output jump_en_i, jump_addr_i, imem_rdata_i, inst_ready_i,
    input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: sequential PC, one outstanding memory read, 2-entry {inst, addr} queue to decode.
// Latency: request in N, data in N+1, inst_valid_o in N+2; redirect to valid target takes 3 cycles.
// Backpressure: requests stop once queued + in-flight would exceed 2; head held while inst_ready_i low.
// Optional build macro IFU_NOP_FILL_EN: idle inst_o shows a NOP (addi x0,x0,0) instead of zero.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst,
  ifu_fetch_if.master bus
);

`ifdef IFU_NOP_FILL_EN
  localparam logic [31:0] IDLE_INST = 32'h0000_0013;
`else
  localparam logic [31:0] IDLE_INST = 32'h0000_0000;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } entry_t;

  entry_t      fifo_q [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q;
  logic        inflight_q;
  logic [31:0] tag_q;
  logic [31:0] fetch_pc_q;

  entry_t      head;
  logic        valid;
  logic        pop;
  logic        push;
  logic        req;
  logic [2:0]  occupancy;

  // Handshake decode: redirect squashes everything; reset forces the strobes low immediately.
  always_comb begin
    head      = fifo_q[rd_ptr_q];
    valid     = !rst && (count_q != 2'd0) && !bus.jump_en_i;
    pop       = valid && bus.inst_ready_i;
    push      = inflight_q && !bus.jump_en_i;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    // occupancy - pop < 2, rearranged to avoid unsigned underflow
    req       = !rst && !bus.jump_en_i && (occupancy < (3'd2 + {2'b00, pop}));
  end

  // Drive the bus; the queue head is only exposed while valid.
  always_comb begin
    bus.imem_req_o   = req;
    bus.imem_addr_o  = fetch_pc_q;
    bus.inst_valid_o = valid;
    bus.inst_o       = valid ? head.inst : IDLE_INST;
    bus.inst_addr_o  = valid ? head.addr : 32'h0;
  end

  // PC, in-flight tracking and queue state; redirect overrides push, pop and request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q      <= 32'h0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (bus.jump_en_i) begin
      fetch_pc_q <= {bus.jump_addr_i[31:2], 2'b00};
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      inflight_q <= req;
      if (req) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
        tag_q      <= fetch_pc_q;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= '{inst: bus.imem_rdata_i, addr: tag_q};
        wr_ptr_q         <= !wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, streaming, backpressure, redirect, wrap, mid-operation reset.
// Memory model answers one cycle after a request with addr ^ 32'hA5A5_0000.
// Inputs change 1 time unit after the rising edge; outputs are compared 1 unit later.
module tb_ifu_fetch;

`ifdef IFU_NOP_FILL_EN
  localparam logic [31:0] FILL = 32'h0000_0013;
`else
  localparam logic [31:0] FILL = 32'h0000_0000;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  logic        mem_q;
  logic [31:0] mem_addr_q;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Always-ready memory: data for a cycle-N request appears in cycle N+1.
  initial begin
    mem_q      = 1'b0;
    mem_addr_q = 32'h0;
  end
  always @(posedge clk) begin
    mem_q      <= bus.imem_req_o;
    mem_addr_q <= bus.imem_addr_o;
  end
  assign bus.imem_rdata_i = mem_q ? (mem_addr_q ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges, release between edges; returns in the first post-reset cycle.
  task automatic do_reset();
    rst = 1'b1;
    bus.jump_en_i = 1'b0;
    bus.jump_addr_i = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.jump_en_i = 1'b0;
    bus.jump_addr_i = 32'h0;
    bus.inst_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.imem_req_o, bus.inst_valid_o, bus.inst_o, bus.inst_addr_o, bus.imem_addr_o}
        !== {1'b0, 1'b0, FILL, 32'h0, 32'h0})
      $display("FAIL reset_outputs: req=%b vld=%b inst=%h iaddr=%h pc=%h, want 0 0 %h 0 0",
               bus.imem_req_o, bus.inst_valid_o, bus.inst_o, bus.inst_addr_o, bus.imem_addr_o, FILL);
    else passes++;
  endtask

  task automatic test_stream();
    bus.inst_ready_i = 1'b1;
    do_reset();
    #1;
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL stream_first_req: req=%b addr=%h vld=%b, want 1 0 0",
               bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o);
    else passes++;
    cyc(); #1;
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o} !== {1'b1, 32'h4, 1'b0})
      $display("FAIL stream_second_req: req=%b addr=%h vld=%b, want 1 4 0",
               bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o);
    else passes++;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      a = 32'(k * 4);
      cyc(); #1;
      checks++;
      if ({bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, bus.imem_req_o, bus.imem_addr_o}
          !== {1'b1, a, word_at(a), 1'b1, a + 32'd8})
        $display("FAIL stream_beat%0d: vld=%b iaddr=%h inst=%h req=%b pc=%h, want 1 %h %h 1 %h",
                 k, bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, bus.imem_req_o,
                 bus.imem_addr_o, a, word_at(a), a + 32'd8);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    bus.inst_ready_i = 1'b0;
    do_reset();
    cyc();
    // cycles 2..4: queue fills to two, requests stop, head stays at 0
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      checks++;
      if ({bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, bus.imem_req_o}
          !== {1'b1, 32'h0, word_at(32'h0), 1'b0})
        $display("FAIL bp_hold%0d: vld=%b iaddr=%h inst=%h req=%b, want 1 0 %h 0",
                 k, bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, bus.imem_req_o, word_at(32'h0));
      else passes++;
    end
    cyc();
    bus.inst_ready_i = 1'b1;
    #1;
    checks++;
    if ({bus.inst_addr_o, bus.imem_req_o, bus.imem_addr_o} !== {32'h0, 1'b1, 32'h8})
      $display("FAIL bp_release: iaddr=%h req=%b pc=%h, want 0 1 8",
               bus.inst_addr_o, bus.imem_req_o, bus.imem_addr_o);
    else passes++;
    for (int k = 1; k < 4; k++) begin
      logic [31:0] a;
      a = 32'(k * 4);
      cyc(); #1;
      checks++;
      if ({bus.inst_valid_o, bus.inst_addr_o, bus.inst_o} !== {1'b1, a, word_at(a)})
        $display("FAIL bp_drain%0d: vld=%b iaddr=%h inst=%h, want 1 %h %h",
                 k, bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, a, word_at(a));
      else passes++;
    end
  endtask

  task automatic test_redirect();
    bus.inst_ready_i = 1'b0;
    do_reset();
    repeat (3) cyc();
    // queue full with 0 and 4 pending
    bus.jump_en_i = 1'b1;
    bus.jump_addr_i = 32'h0000_0100;
    #1;
    checks++;
    if ({bus.inst_valid_o, bus.imem_req_o, bus.inst_o, bus.inst_addr_o} !== {1'b0, 1'b0, FILL, 32'h0})
      $display("FAIL jump_cycle: vld=%b req=%b inst=%h iaddr=%h, want 0 0 %h 0",
               bus.inst_valid_o, bus.imem_req_o, bus.inst_o, bus.inst_addr_o, FILL);
    else passes++;
    cyc();
    bus.jump_en_i = 1'b0;
    bus.inst_ready_i = 1'b1;
    #1;
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o} !== {1'b1, 32'h100, 1'b0})
      $display("FAIL jump_target_req: req=%b pc=%h vld=%b, want 1 100 0",
               bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o);
    else passes++;
    cyc(); #1;
    checks++;
    if (bus.inst_valid_o !== 1'b0)
      $display("FAIL jump_no_stale: vld=%b, want 0", bus.inst_valid_o);
    else passes++;
    cyc(); #1;
    checks++;
    if ({bus.inst_valid_o, bus.inst_addr_o, bus.inst_o} !== {1'b1, 32'h100, word_at(32'h100)})
      $display("FAIL jump_first_inst: vld=%b iaddr=%h inst=%h, want 1 100 %h",
               bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, word_at(32'h100));
    else passes++;
    cyc(); #1;
    checks++;
    if ({bus.inst_valid_o, bus.inst_addr_o} !== {1'b1, 32'h104})
      $display("FAIL jump_second_inst: vld=%b iaddr=%h, want 1 104",
               bus.inst_valid_o, bus.inst_addr_o);
    else passes++;
  endtask

  task automatic test_wrap();
    bus.inst_ready_i = 1'b1;
    do_reset();
    cyc();
    // read of address 0 is in flight here and must be thrown away
    bus.jump_en_i = 1'b1;
    bus.jump_addr_i = 32'hFFFF_FFFE;
    #1;
    checks++;
    if ({bus.imem_req_o, bus.inst_valid_o} !== 2'b00)
      $display("FAIL wrap_jump_cycle: req=%b vld=%b, want 0 0", bus.imem_req_o, bus.inst_valid_o);
    else passes++;
    cyc();
    bus.jump_en_i = 1'b0;
    #1;
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o} !== {1'b1, 32'hFFFF_FFFC, 1'b0})
      $display("FAIL wrap_aligned_req: req=%b pc=%h vld=%b, want 1 fffffffc 0",
               bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o);
    else passes++;
    cyc(); #1;
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL wrap_to_zero: req=%b pc=%h vld=%b, want 1 0 0",
               bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o);
    else passes++;
    cyc(); #1;
    checks++;
    if ({bus.inst_valid_o, bus.inst_addr_o, bus.inst_o} !== {1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC})
      $display("FAIL wrap_top_inst: vld=%b iaddr=%h inst=%h, want 1 fffffffc 5a5afffc",
               bus.inst_valid_o, bus.inst_addr_o, bus.inst_o);
    else passes++;
    cyc(); #1;
    checks++;
    if ({bus.inst_valid_o, bus.inst_addr_o, bus.inst_o} !== {1'b1, 32'h0, 32'hA5A5_0000})
      $display("FAIL wrap_zero_inst: vld=%b iaddr=%h inst=%h, want 1 0 a5a50000",
               bus.inst_valid_o, bus.inst_addr_o, bus.inst_o);
    else passes++;
  endtask

  task automatic test_mid_reset();
    bus.inst_ready_i = 1'b0;
    do_reset();
    repeat (3) cyc();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.inst_valid_o, bus.imem_req_o, bus.inst_o, bus.imem_addr_o} !== {1'b0, 1'b0, FILL, 32'h0})
      $display("FAIL midrst_drop: vld=%b req=%b inst=%h pc=%h, want 0 0 %h 0",
               bus.inst_valid_o, bus.imem_req_o, bus.inst_o, bus.imem_addr_o, FILL);
    else passes++;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL midrst_restart: req=%b pc=%h vld=%b, want 1 0 0",
               bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o);
    else passes++;
    cyc();
    cyc(); #1;
    checks++;
    if ({bus.inst_valid_o, bus.inst_addr_o, bus.inst_o} !== {1'b1, 32'h0, word_at(32'h0)})
      $display("FAIL midrst_first_inst: vld=%b iaddr=%h inst=%h, want 1 0 %h",
               bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, word_at(32'h0));
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    bus.jump_en_i = 1'b0;
    bus.jump_addr_i = 32'h0;
    bus.inst_ready_i = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
